mmc1_mapper: RTL and testbench

- MMC1 (SxROM) bank-switching mapper on the CPU bus, in parallel with the memory manager.
- Decodes CPU writes to $8000-$FFFF through the MMC1 5-bit serial load protocol into four internal registers.
- Drives translated PRG-ROM and CHR addresses, PRG-RAM select and nametable mirroring to the memory manager in place of its fixed NT_MIRRORING setting.
- Timing is qualified by the CPU phase-2 falling strobe.

---
 rtl/mmc1_mapper_if.sv | 29 ++
 rtl/mmc1_mapper.sv | 91 +++++++++
 tb/tb_mmc1_mapper.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mmc1_mapper_if.sv
// mmc1_mapper_if: CPU/PPU bus bundle between the CPU-side bus master and the MMC1 mapper.
//   master: drives ph2_falling, cpu_addr, cpu_rnw, cpu_data_in, ppu_addr;
//           receives prg_addr, prg_rom_cs, prg_ram_cs, chr_addr, mirroring.
//   slave : the mapper, with the opposite directions.
interface mmc1_mapper_if #(
    parameter int PRG_ADDR_W = 18,
    parameter int CHR_ADDR_W = 17
);
    logic                  ph2_falling;
    logic [15:0]           cpu_addr;
    logic                  cpu_rnw;
    logic [7:0]            cpu_data_in;
    logic [13:0]           ppu_addr;
    logic [PRG_ADDR_W-1:0] prg_addr;
    logic                  prg_rom_cs;
    logic                  prg_ram_cs;
    logic [CHR_ADDR_W-1:0] chr_addr;
    logic [1:0]            mirroring;

    modport master (
        output ph2_falling, cpu_addr, cpu_rnw, cpu_data_in, ppu_addr,
        input  prg_addr, prg_rom_cs, prg_ram_cs, chr_addr, mirroring
    );

    modport slave (
        input  ph2_falling, cpu_addr, cpu_rnw, cpu_data_in, ppu_addr,
        output prg_addr, prg_rom_cs, prg_ram_cs, chr_addr, mirroring
    );
endinterface

// File: rtl/mmc1_mapper.sv
// mmc1_mapper: MMC1 (SxROM) bank-switching mapper fed by the 5-bit serial load protocol.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : mmc1_mapper_if.slave
//          in : ph2_falling (bus sample strobe), cpu_addr, cpu_rnw, cpu_data_in, ppu_addr
//          out: prg_addr, prg_rom_cs, prg_ram_cs, chr_addr, mirroring
// Optional macro MMC1_CONSEC_WRITE_FILTER_EN: ignore a non-reset write that directly follows
// another mapper write (RMW instructions then load only once).
module mmc1_mapper #(
    parameter int       PRG_ADDR_W    = 18,
    parameter int       CHR_ADDR_W    = 17,
    parameter bit [3:0] LAST_PRG_BANK = 4'hF
) (
    input  logic             clk,
    input  logic             rstn,
    mmc1_mapper_if.slave     bus
);
    logic [4:0]  shift_q, shift_d;
    logic [4:0]  control_q, control_d;
    logic [4:0]  chr0_q, chr0_d;
    logic [4:0]  chr1_q, chr1_d;
    logic [4:0]  prg_q, prg_d;
    logic        wr_evt, blocked, load, commit, rst_wr;
    logic [4:0]  value;
    logic [1:0]  sel;
    logic [3:0]  bank;
    logic [4:0]  chr_bank;
    logic [17:0] prg_full;
    logic [16:0] chr_full;
    logic        unused;

    assign wr_evt = bus.ph2_falling & ~bus.cpu_rnw & bus.cpu_addr[15];
    assign rst_wr = wr_evt & bus.cpu_data_in[7];

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    logic wr_prev_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wr_prev_q <= 1'b0;
        else if (bus.ph2_falling)
            wr_prev_q <= wr_evt;
    end
    assign blocked = wr_prev_q;
`else
    assign blocked = 1'b0;
`endif

    assign load   = wr_evt & ~bus.cpu_data_in[7] & ~blocked;
    // the marker bit reaching bit 0 means this write carries the fifth bit
    assign commit = load & shift_q[0];
    assign value  = {bus.cpu_data_in[0], shift_q[4:1]};
    assign sel    = bus.cpu_addr[14:13];

    assign shift_d   = (rst_wr | commit) ? 5'b10000 : load ? value : shift_q;
    assign control_d = rst_wr ? (control_q | 5'h0C) : (commit && sel == 2'd0) ? value : control_q;
    assign chr0_d    = (commit && sel == 2'd1) ? value : chr0_q;
    assign chr1_d    = (commit && sel == 2'd2) ? value : chr1_q;
    assign prg_d     = (commit && sel == 2'd3) ? value : prg_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q   <= 5'b10000;
            control_q <= 5'h0C;
            chr0_q    <= 5'h00;
            chr1_q    <= 5'h00;
            prg_q     <= 5'h00;
        end else begin
            shift_q   <= shift_d;
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
        end
    end

    // mode 2 fixes bank 0 at $8000, mode 3 fixes the last bank at $C000
    assign bank     = (control_q[3:2] == 2'd2) ? (bus.cpu_addr[14] ? prg_q[3:0] : 4'h0)
                                               : (bus.cpu_addr[14] ? LAST_PRG_BANK : prg_q[3:0]);
    assign prg_full = control_q[3] ? {bank, bus.cpu_addr[13:0]} : {prg_q[3:1], bus.cpu_addr[14:0]};

    assign chr_bank = bus.ppu_addr[12] ? chr1_q : chr0_q;
    assign chr_full = control_q[4] ? {chr_bank, bus.ppu_addr[11:0]} : {chr0_q[4:1], bus.ppu_addr[12:0]};

    assign bus.prg_addr   = PRG_ADDR_W'(prg_full);
    assign bus.chr_addr   = CHR_ADDR_W'(chr_full);
    assign bus.prg_rom_cs = bus.cpu_addr[15];
    assign bus.prg_ram_cs = (bus.cpu_addr[15:13] == 3'b011) & ~prg_q[4];
    assign bus.mirroring  = control_q[1:0];

    assign unused = ^{bus.cpu_data_in[6:1], bus.ppu_addr[13]};
endmodule

// File: tb/tb_mmc1_mapper.sv
// tb_mmc1_mapper: directed scoreboard bench for mmc1_mapper.
module tb_mmc1_mapper;
    localparam int P = 0, C = 1, M = 2, R = 3, O = 4;

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    localparam logic [17:0] PAIR_M5 = 18'd2, PAIR_M6 = 18'd3;
`else
    localparam logic [17:0] PAIR_M5 = 18'd1, PAIR_M6 = 18'd1;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [17:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mmc1_mapper_if #(.PRG_ADDR_W(18), .CHR_ADDR_W(17)) bus ();

    mmc1_mapper #(.PRG_ADDR_W(18), .CHR_ADDR_W(17), .LAST_PRG_BANK(4'hF)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic cyc(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr    = a;
        bus.cpu_rnw     = rnw;
        bus.cpu_data_in = d;
        bus.ph2_falling = 1'b1;
        @(negedge clk);
        bus.ph2_falling = 1'b0;
        bus.cpu_rnw     = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(a, 1'b0, d);
        cyc(16'h0000, 1'b1, 8'h00);
    endtask

    task automatic wr_bits(input logic [15:0] a, input logic [4:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) wr(a, {7'b0, v[i]});
    endtask

    task automatic wr5(input logic [15:0] a, input logic [4:0] v);
        wr_bits(a, v, 0, 4);
    endtask

    task automatic probe(input string tag, input int sel, input logic [15:0] a,
                         input logic [13:0] p, input logic [17:0] e);
        exp_t        o;
        logic [17:0] obs;
        bus.cpu_addr = a;
        bus.ppu_addr = p;
        sb.push_back('{tag, sel, e});
        #1;
        o = sb.pop_front();
        case (o.sel)
            P:       obs = bus.prg_addr;
            C:       obs = {1'b0, bus.chr_addr};
            M:       obs = {16'b0, bus.mirroring};
            R:       obs = {17'b0, bus.prg_ram_cs};
            default: obs = {17'b0, bus.prg_rom_cs};
        endcase
        checks++;
        assert (obs === o.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", o.tag, obs, o.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ph2_falling = 1'b0;
        bus.cpu_rnw     = 1'b1;
        bus.cpu_addr    = 16'h0000;
        bus.cpu_data_in = 8'h00;
        bus.ppu_addr    = 14'h0000;
        #23 rstn = 1'b0;
        probe("rst_async_mirr", M, 16'hC123, 14'h1ABC, 18'd0);
        #6 rstn = 1'b1;
        probe("rst_prg_c123", P, 16'hC123, 14'h1ABC, 18'h3C123);
        probe("rst_ram_cs", R, 16'h6000, 14'h1ABC, 18'd1);
        probe("rst_rom_cs_6000", O, 16'h6000, 14'h1ABC, 18'd0);
        probe("rst_rom_cs_8000", O, 16'h8000, 14'h1ABC, 18'd1);
        probe("rst_chr_1abc", C, 16'h0000, 14'h1ABC, 18'h01ABC);

        wr_bits(16'h8000, 5'h02, 0, 3);
        probe("ctl_4bits_mirr", M, 16'h0000, 14'h0000, 18'd0);
        wr_bits(16'h8000, 5'h02, 4, 4);
        probe("ctl_5bits_mirr", M, 16'h0000, 14'h0000, 18'd2);
        wr5(16'hE000, 5'h05);
        probe("m0_prg_8000", P, 16'h8000, 14'h0000, 18'h10000);
        probe("m0_prg_c000", P, 16'hC000, 14'h0000, 18'h14000);
        probe("m0_ram_cs", R, 16'h6000, 14'h0000, 18'd1);

        wr5(16'h8000, 5'h0A);
        probe("m2_prg_8000", P, 16'h8000, 14'h0000, 18'h00000);
        probe("m2_prg_c123", P, 16'hC123, 14'h0000, 18'h14123);
        probe("m2_mirr", M, 16'h0000, 14'h0000, 18'd2);
        wr5(16'h8000, 5'h0E);
        probe("m3_prg_8000", P, 16'h8000, 14'h0000, 18'h14000);
        probe("m3_prg_c000", P, 16'hC000, 14'h0000, 18'h3C000);

        wr5(16'h8000, 5'h02);
        wr_bits(16'h8000, 5'h07, 0, 2);
        wr(16'h8000, 8'h80);
        probe("rstwr_prg_c000", P, 16'hC000, 14'h0000, 18'h3C000);
        probe("rstwr_mirr", M, 16'h0000, 14'h0000, 18'd2);
        wr_bits(16'h8000, 5'h01, 0, 1);
        probe("rstwr_no_early", M, 16'h0000, 14'h0000, 18'd2);
        wr_bits(16'h8000, 5'h01, 2, 4);
        probe("rstwr_commit", M, 16'h0000, 14'h0000, 18'd1);
        probe("rstwr_m0_c000", P, 16'hC000, 14'h0000, 18'h14000);

        wr5(16'h8000, 5'h1E);
        wr5(16'hA000, 5'h10);
        wr5(16'hC000, 5'h03);
        probe("chr4k_0abc", C, 16'h0000, 14'h0ABC, 18'h10ABC);
        probe("chr4k_1abc", C, 16'h0000, 14'h1ABC, 18'h03ABC);
        wr5(16'h8000, 5'h0E);
        probe("chr8k_1abc", C, 16'h0000, 14'h1ABC, 18'h11ABC);

        wr5(16'hE000, 5'h10);
        probe("ramdis_cs", R, 16'h6000, 14'h0000, 18'd0);
        probe("ramdis_c000", P, 16'hC000, 14'h0000, 18'h3C000);
        probe("ramdis_8000", P, 16'h8000, 14'h0000, 18'h00000);

        cyc(16'h8000, 1'b0, 8'h01);
        wr(16'h8000, 8'h00);
        wr(16'h8000, 8'h01);
        wr(16'h8000, 8'h00);
        wr(16'h8000, 8'h00);
        probe("pair_5writes", M, 16'h0000, 14'h0000, PAIR_M5);
        wr(16'h8000, 8'h00);
        probe("pair_6writes", M, 16'h0000, 14'h0000, PAIR_M6);
        wr(16'h8000, 8'h80);
        probe("pair_after_rst", M, 16'h0000, 14'h0000, PAIR_M6);

        wr_bits(16'h8000, 5'h03, 0, 3);
        @(negedge clk);
        #1 rstn = 1'b0;
        probe("midseq_rst_mirr", M, 16'h0000, 14'h0000, 18'd0);
        probe("midseq_rst_c000", P, 16'hC000, 14'h0000, 18'h3C000);
        probe("midseq_rst_ram", R, 16'h6000, 14'h0000, 18'd1);
        rstn = 1'b1;
        wr_bits(16'h8000, 5'h03, 0, 0);
        probe("midseq_1write", M, 16'h0000, 14'h0000, 18'd0);
        wr_bits(16'h8000, 5'h03, 1, 3);
        probe("midseq_4writes", M, 16'h0000, 14'h0000, 18'd0);
        wr_bits(16'h8000, 5'h03, 4, 4);
        probe("midseq_commit", M, 16'h0000, 14'h0000, 18'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
